jtag_tap_controller: RTL and testbench

IEEE 1149.1-style TAP controller that drives the control side of the ripple-adder boundary-scan chain. It decodes TMS into the 16-state TAP FSM and holds a 2-bit instruction register plus BYPASS and IDCODE data registers. It generates `ShiftDR`, `ClockDR`, `UpdateDR` and `Mode` for the `BoundaryScanCell` chain, and muxes the serial return path onto `TDO`.

---
 rtl/jtag_tap_controller.sv | 121 ++++++++++++
 tb/tb_jtag_tap_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_controller.sv
// 1149.1 TAP controller: TMS-decoded 16-state FSM, 2-bit IR, BYPASS/IDCODE DRs,
// falling-edge strobes for an external boundary-scan chain and a registered TDO mux.
module jtag_tap_controller #(
   parameter logic [31:0] IDCODE = 32'h1000_0001
) (
   input  logic       TCK,
   input  logic       TRST_n,
   input  logic       TMS,
   input  logic       TDI,
   input  logic       bsr_tdo,
   output logic       TDO,
   output logic       TDO_en,
   output logic       ShiftDR,
   output logic       ClockDR,
   output logic       UpdateDR,
   output logic       Mode,
   output logic [3:0] tap_state
);

   typedef enum logic [3:0] {
      TLR    = 4'd0,  RTI    = 4'd1,
      SEL_DR = 4'd2,  CAP_DR = 4'd3,  SH_DR  = 4'd4,  EX1_DR = 4'd5,
      PAU_DR = 4'd6,  EX2_DR = 4'd7,  UPD_DR = 4'd8,
      SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11, EX1_IR = 4'd12,
      PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
   } state_t;

   localparam logic [1:0] I_EXTEST = 2'b00;
   localparam logic [1:0] I_IDCODE = 2'b10;
   localparam logic [1:0] I_BYPASS = 2'b11;

   state_t      state, state_nx;
   logic [1:0]  ir_sh, ir_lat, ir;
   logic [31:0] id_sh;
   logic        byp, cdr_en, bsr_sel, tdo_nx;

   always_ff @(posedge TCK or negedge TRST_n) begin
      if (!TRST_n) state <= TLR;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         TLR:    state_nx = TMS ? TLR    : RTI;
         RTI:    state_nx = TMS ? SEL_DR : RTI;
         SEL_DR: state_nx = TMS ? SEL_IR : CAP_DR;
         CAP_DR: state_nx = TMS ? EX1_DR : SH_DR;
         SH_DR:  state_nx = TMS ? EX1_DR : SH_DR;
         EX1_DR: state_nx = TMS ? UPD_DR : PAU_DR;
         PAU_DR: state_nx = TMS ? EX2_DR : PAU_DR;
         EX2_DR: state_nx = TMS ? UPD_DR : SH_DR;
         UPD_DR: state_nx = TMS ? SEL_DR : RTI;
         SEL_IR: state_nx = TMS ? TLR    : CAP_IR;
         CAP_IR: state_nx = TMS ? EX1_IR : SH_IR;
         SH_IR:  state_nx = TMS ? EX1_IR : SH_IR;
         EX1_IR: state_nx = TMS ? UPD_IR : PAU_IR;
         PAU_IR: state_nx = TMS ? EX2_IR : PAU_IR;
         EX2_IR: state_nx = TMS ? UPD_IR : SH_IR;
         UPD_IR: state_nx = TMS ? SEL_DR : RTI;
      endcase
   end

   // The latch itself reloads on the falling edge; masking it in TLR makes the
   // IDCODE default (and Mode=0) visible from the rising edge that enters TLR.
   assign ir        = (state == TLR) ? I_IDCODE : ir_lat;
   assign bsr_sel   = ~ir[1];
   assign Mode      = (ir == I_EXTEST);
   assign tap_state = state;
   assign ClockDR   = TCK & cdr_en;

   always_ff @(posedge TCK or negedge TRST_n) begin
      if (!TRST_n) begin
         ir_sh <= 2'b01;
         id_sh <= IDCODE;
         byp   <= 1'b0;
      end else begin
         if (state == CAP_IR)     ir_sh <= 2'b01;
         else if (state == SH_IR) ir_sh <= {TDI, ir_sh[1]};
         if (state == CAP_DR) begin
            if (ir == I_IDCODE) id_sh <= IDCODE;
            if (ir == I_BYPASS) byp   <= 1'b0;
         end else if (state == SH_DR) begin
            if (ir == I_IDCODE) id_sh <= {TDI, id_sh[31:1]};
            if (ir == I_BYPASS) byp   <= TDI;
         end
      end
   end

   always_comb begin
      tdo_nx = 1'b0;
      if (state == SH_IR) begin
         tdo_nx = ir_sh[0];
      end else if (state == SH_DR) begin
         if (bsr_sel)             tdo_nx = bsr_tdo;
         else if (ir == I_IDCODE) tdo_nx = id_sh[0];
         else                     tdo_nx = byp;
      end
   end

   // cdr_en only moves while TCK is low, so the ClockDR AND gate cannot glitch.
   always_ff @(negedge TCK or negedge TRST_n) begin
      if (!TRST_n) begin
         ir_lat   <= I_IDCODE;
         ShiftDR  <= 1'b0;
         cdr_en   <= 1'b0;
         UpdateDR <= 1'b0;
         TDO      <= 1'b0;
         TDO_en   <= 1'b0;
      end else begin
         if (state == TLR)         ir_lat <= I_IDCODE;
         else if (state == UPD_IR) ir_lat <= ir_sh;
         ShiftDR  <= bsr_sel && (state == SH_DR);
         cdr_en   <= bsr_sel && ((state == CAP_DR) || (state == SH_DR));
         UpdateDR <= bsr_sel && (state == UPD_DR);
         TDO_en   <= (state == SH_IR) || (state == SH_DR);
         TDO      <= tdo_nx;
      end
   end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Bench for jtag_tap_controller: arc-walk vector table, directed scan sequences,
// and random TMS/TDI traffic checked against a table-driven reference model.
`timescale 1ns/1ps
module tb_jtag_tap_controller;

   localparam logic [31:0] IDV = 32'h1000_0001;

   logic       TCK = 1'b0;
   logic       TRST_n, TMS, TDI, bsr_tdo;
   logic       TDO, TDO_en, ShiftDR, ClockDR, UpdateDR, Mode;
   logic [3:0] tap_state;

   int errors = 0;
   int checks = 0;

   jtag_tap_controller #(.IDCODE(IDV)) dut (
      .TCK(TCK), .TRST_n(TRST_n), .TMS(TMS), .TDI(TDI), .bsr_tdo(bsr_tdo),
      .TDO(TDO), .TDO_en(TDO_en), .ShiftDR(ShiftDR), .ClockDR(ClockDR),
      .UpdateDR(UpdateDR), .Mode(Mode), .tap_state(tap_state)
   );

   always #5 TCK = ~TCK;

   // strobe monitors
   int         cdr_cnt = 0;
   int         upd_cnt = 0;
   logic [7:0] sd_bits = '0;
   time        t_up = 0;
   time        upd_w = 0;
   always @(posedge ClockDR) begin
      cdr_cnt++;
      sd_bits = {sd_bits[6:0], ShiftDR};
   end
   always @(posedge UpdateDR) begin
      upd_cnt++;
      t_up = $time;
   end
   always @(negedge UpdateDR) upd_w = $time - t_up;

   // reference model: transition table indexed [state][tms]
   int       nxt[16][2];
   int       m_state;
   bit [1:0] m_ir, m_irsh;
   bit [31:0] m_id;
   bit       m_byp, m_sd, m_cdr, m_upd, m_tdo, m_tdoen;

   typedef struct {
      logic       tms;
      logic [3:0] exp_state;
   } vec_t;
   vec_t vecs[43];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic model_reset();
      m_state = 0; m_ir = 2'd2; m_irsh = 2'd1; m_byp = 0; m_id = IDV;
      m_sd = 0; m_cdr = 0; m_upd = 0; m_tdo = 0; m_tdoen = 0;
   endtask

   task automatic step(input logic tms, input logic tdi, input logic bsr, output logic tdo_s);
      bit sel;
      TMS = tms; TDI = tdi; bsr_tdo = bsr;
      @(posedge TCK);
      if (m_state == 10)      m_irsh = 2'd1;
      else if (m_state == 11) m_irsh = (m_irsh >> 1) | (2'(tdi) << 1);
      if (m_state == 3) begin
         if (m_ir == 2) m_id = IDV;
         if (m_ir == 3) m_byp = 0;
      end else if (m_state == 4) begin
         if (m_ir == 2) m_id = (m_id >> 1) | (32'(tdi) << 31);
         if (m_ir == 3) m_byp = tdi;
      end
      m_state = nxt[m_state][tms ? 1 : 0];
      if (m_state == 0) m_ir = 2'd2;
      #1;
      chk("state", 32'(tap_state), 32'(m_state));
      chk("mode_hi", 32'(Mode), 32'(m_ir == 0));
      chk("clockdr_hi", 32'(ClockDR), 32'(m_cdr));
      chk("shiftdr_hi", 32'(ShiftDR), 32'(m_sd));
      chk("updatedr_hi", 32'(UpdateDR), 32'(m_upd));
      chk("tdo_hold", 32'(TDO), 32'(m_tdo));
      @(negedge TCK);
      if (m_state == 15) m_ir = m_irsh;
      sel     = (m_ir < 2);
      m_sd    = sel && (m_state == 4);
      m_cdr   = sel && (m_state == 3 || m_state == 4);
      m_upd   = sel && (m_state == 8);
      m_tdoen = (m_state == 4 || m_state == 11);
      m_tdo   = 0;
      if (m_state == 11) m_tdo = m_irsh[0];
      else if (m_state == 4) m_tdo = sel ? bsr : ((m_ir == 2) ? m_id[0] : m_byp);
      #1;
      chk("tdo", 32'(TDO), 32'(m_tdo));
      chk("tdo_en", 32'(TDO_en), 32'(m_tdoen));
      chk("shiftdr", 32'(ShiftDR), 32'(m_sd));
      chk("updatedr", 32'(UpdateDR), 32'(m_upd));
      chk("mode", 32'(Mode), 32'(m_ir == 0));
      chk("clockdr_lo", 32'(ClockDR), 32'd0);
      tdo_s = TDO;
   endtask

   // RTI -> load IR with v -> RTI
   task automatic ir_scan(input logic [1:0] v);
      logic d;
      step(1, rb(), rb(), d); step(1, rb(), rb(), d);
      step(0, rb(), rb(), d); step(0, rb(), rb(), d);
      step(0, v[0], rb(), d); step(1, v[1], rb(), d);
      step(1, rb(), rb(), d); step(0, rb(), rb(), d);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      string      walk_tms;
      int         walk_st[43];
      logic       d, o0, o1, o2, o3, b;
      logic [31:0] w;
      int         base_c, base_u;

      nxt[0]  = '{1, 0};   nxt[1]  = '{1, 2};   nxt[2]  = '{3, 9};   nxt[3]  = '{4, 5};
      nxt[4]  = '{4, 5};   nxt[5]  = '{6, 8};   nxt[6]  = '{6, 7};   nxt[7]  = '{4, 8};
      nxt[8]  = '{1, 2};   nxt[9]  = '{10, 0};  nxt[10] = '{11, 12}; nxt[11] = '{11, 12};
      nxt[12] = '{13, 15}; nxt[13] = '{13, 14}; nxt[14] = '{11, 15}; nxt[15] = '{1, 2};
      walk_tms = {"1001110101", "0010011110", "0010010111", "1011010010", "110"};
      walk_st  = '{0, 1, 1, 2, 9, 0, 1, 2, 3, 5,
                   6, 6, 7, 4, 4, 5, 8, 2, 9, 10,
                   11, 11, 12, 13, 13, 14, 11, 12, 15, 2,
                   9, 10, 12, 15, 1, 2, 3, 4, 5, 6,
                   7, 8, 1};
      for (int i = 0; i < 43; i++) begin
         vecs[i].tms       = (walk_tms[i] == "1");
         vecs[i].exp_state = 4'(walk_st[i]);
      end

      // power-on reset
      TRST_n = 1'b0; TMS = 1'b1; TDI = 1'b0; bsr_tdo = 1'b0;
      repeat (2) @(negedge TCK);
      #1;
      chk("rst_state", 32'(tap_state), 32'd0);
      chk("rst_tdo", 32'(TDO), 32'd0);
      chk("rst_tdo_en", 32'(TDO_en), 32'd0);
      chk("rst_shiftdr", 32'(ShiftDR), 32'd0);
      chk("rst_updatedr", 32'(UpdateDR), 32'd0);
      chk("rst_mode", 32'(Mode), 32'd0);
      TRST_n = 1'b1;
      model_reset();

      // arc walk
      for (int i = 0; i < 43; i++) begin
         step(vecs[i].tms, rb(), rb(), d);
         chk("walk_state", 32'(tap_state), 32'(vecs[i].exp_state));
      end

      // IR scan of EXTEST: captured 01 comes out LSB first
      ir_scan(2'b11);
      step(1, rb(), rb(), d); step(1, rb(), rb(), d); step(0, rb(), rb(), d);
      step(0, rb(), rb(), o0);
      step(0, 1'b0, rb(), o1);
      chk("ir_capture_tdo", 32'({o0, o1}), 32'b10);
      step(1, 1'b0, rb(), d);
      chk("mode_before_upd", 32'(Mode), 32'd0);
      step(1, rb(), rb(), d);
      chk("mode_after_updir", 32'(Mode), 32'd1);
      step(0, rb(), rb(), d);

      // EXTEST DR scan of a 4-cell chain
      base_c = cdr_cnt; base_u = upd_cnt;
      step(1, rb(), rb(), d); step(0, rb(), rb(), d);
      for (int k = 0; k < 4; k++) begin
         b = rb();
         step(0, rb(), b, o0);
         chk("extest_tdo_follows_bsr", 32'(o0), 32'(b));
      end
      step(1, rb(), rb(), d); step(1, rb(), rb(), d); step(0, rb(), rb(), d);
      chk("extest_clockdr_pulses", 32'(cdr_cnt - base_c), 32'd5);
      chk("extest_shiftdr_pattern", 32'(sd_bits[4:0]), 32'b01111);
      chk("extest_updatedr_pulses", 32'(upd_cnt - base_u), 32'd1);
      chk("extest_updatedr_width", 32'(upd_w), 32'd10);

      // five TMS=1 edges from Shift-IR
      step(1, rb(), rb(), d); step(1, rb(), rb(), d);
      step(0, rb(), rb(), d); step(0, rb(), rb(), d);
      for (int k = 0; k < 5; k++) step(1, rb(), rb(), d);
      chk("tms5_state", 32'(tap_state), 32'd0);
      chk("tms5_mode", 32'(Mode), 32'd0);
      step(0, rb(), rb(), d); step(1, rb(), rb(), d); step(0, rb(), rb(), d);
      step(0, rb(), 1'b0, o0);
      chk("tms5_ir_is_idcode", 32'(o0), 32'd1);
      step(1, rb(), rb(), d); step(1, rb(), rb(), d); step(0, rb(), rb(), d);

      // BYPASS: one-bit delay, no BSR strobes
      ir_scan(2'b11);
      base_c = cdr_cnt; base_u = upd_cnt;
      step(1, rb(), rb(), d); step(0, rb(), rb(), d);
      step(0, rb(), rb(), o0);
      step(0, 1'b1, rb(), o1);
      step(0, 1'b0, rb(), o2);
      step(0, 1'b1, rb(), o3);
      step(1, 1'b1, rb(), d);
      chk("bypass_tdo", 32'({o0, o1, o2, o3}), 32'b0101);
      step(1, rb(), rb(), d); step(0, rb(), rb(), d);
      chk("bypass_no_clockdr", 32'(cdr_cnt - base_c), 32'd0);
      chk("bypass_no_updatedr", 32'(upd_cnt - base_u), 32'd0);

      // IDCODE with a pause after 8 bits
      ir_scan(2'b10);
      w = '0;
      step(1, rb(), rb(), d); step(0, rb(), rb(), d);
      for (int k = 0; k < 8; k++) begin step(0, rb(), rb(), o0); w[k] = o0; end
      step(1, rb(), rb(), d);
      for (int k = 0; k < 3; k++) begin
         step(0, rb(), rb(), d);
         chk("pause_tdo_en", 32'(TDO_en), 32'd0);
      end
      step(1, rb(), rb(), d);
      for (int k = 8; k < 32; k++) begin step(0, rb(), rb(), o0); w[k] = o0; end
      step(1, rb(), rb(), d);
      chk("pause_idcode", w, IDV);
      step(1, rb(), rb(), d); step(0, rb(), rb(), d);

      // asynchronous reset in the middle of an EXTEST Shift-DR
      ir_scan(2'b00);
      step(1, rb(), rb(), d); step(0, rb(), rb(), d); step(0, rb(), rb(), d);
      TMS = 1'b0;
      @(posedge TCK);
      #1;
      chk("pre_rst_clockdr", 32'(ClockDR), 32'd1);
      #1 TRST_n = 1'b0;
      #1;
      chk("arst_state", 32'(tap_state), 32'd0);
      chk("arst_mode", 32'(Mode), 32'd0);
      chk("arst_clockdr", 32'(ClockDR), 32'd0);
      chk("arst_shiftdr", 32'(ShiftDR), 32'd0);
      chk("arst_updatedr", 32'(UpdateDR), 32'd0);
      chk("arst_tdo", 32'(TDO), 32'd0);
      chk("arst_tdo_en", 32'(TDO_en), 32'd0);
      @(negedge TCK);
      #1 TRST_n = 1'b1;
      model_reset();
      w = '0;
      step(0, rb(), rb(), d); step(1, rb(), rb(), d); step(0, rb(), rb(), d);
      for (int k = 0; k < 32; k++) begin step(0, rb(), rb(), o0); w[k] = o0; end
      step(1, rb(), rb(), d);
      chk("arst_idcode", w, IDV);
      step(1, rb(), rb(), d); step(0, rb(), rb(), d);

      // random traffic against the model
      for (int k = 0; k < 500; k++)
         step($urandom_range(0, 3) == 0, rb(), rb(), d);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
